apb_ram_ws: RTL

Parametrised APB3 slave RAM, the successor to the fixed 32-bit `apb_ram`, with configurable data/address width, depth and wait states. Out-of-range accesses are reported on `pslverr`, and byte-strobed writes are an optional build feature. It sits on the APB bus as a scratch/configuration memory behind the APB bridge and serves as the reference slave for APB bench development.

---
 rtl/apb_ram_ws.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/apb_ram_ws.sv
// ----------------------------------------------------------------------------
// apb_ram_ws
//   APB3 slave RAM with configurable data/address width, depth and a fixed
//   number of wait states per transfer. Accesses whose word index falls
//   outside the memory complete with pslverr set; error writes leave the
//   memory untouched and error reads return zero.
//
//   Optional feature macro: APB_RAM_PSTRB_EN
//     defined   : pstrb port exists, writes update only strobed bytes
//     undefined : no pstrb port, every non-error write updates the full word
//
// Parameters
//   ADDR_W       paddr width (byte address)
//   DATA_W       data width: 8, 16, 32 or 64
//   DEPTH        number of DATA_W-bit words (any value >= 1)
//   WAIT_CYCLES  access-phase cycles with pready low before completion, 0..15
//
// Ports
//   pclk     in   bus clock, rising-edge active
//   prst     in   asynchronous active-high reset
//   psel     in   slave select
//   penable  in   access phase
//   pwrite   in   1 = write, 0 = read
//   paddr    in   byte address
//   pwdata   in   write data
//   pstrb    in   byte write strobes (APB_RAM_PSTRB_EN only)
//   prdata   out  read data, valid while pready is high, held until next read
//   pready   out  transfer completion (high exactly while in READY)
//   pslverr  out  transfer error, only ever high together with pready
// ----------------------------------------------------------------------------
module apb_ram_ws #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                pclk,
    input  logic                prst,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
`ifdef APB_RAM_PSTRB_EN
    input  logic [DATA_W/8-1:0] pstrb,
`endif
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr
);

    localparam int NBYTES = DATA_W / 8;
    localparam int SHIFT  = $clog2(NBYTES);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;

    // Control state
    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, err_q;

    // Transfer attributes captured in the setup cycle
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [NBYTES-1:0] strb_q;

    // Registered outputs
    logic [DATA_W-1:0] prdata_q;
    logic              pready_q, pslverr_q;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Decode of the address presented on the bus this cycle
    logic [ADDR_W-1:0] setup_word;
    logic [IDX_W-1:0]  setup_idx;
    logic              setup_err;
    logic [NBYTES-1:0] setup_strb;

    assign setup_word = paddr >> SHIFT;
    assign setup_idx  = setup_word[IDX_W-1:0];
    assign setup_err  = (setup_word >= ADDR_W'(DEPTH));

`ifdef APB_RAM_PSTRB_EN
    assign setup_strb = pstrb;
`else
    assign setup_strb = '1;
`endif

    logic              cap;
    logic              xfer_wr, xfer_err;
    logic [IDX_W-1:0]  xfer_idx;
    logic [DATA_W-1:0] rd_word;
    logic              do_write;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // penable without a preceding setup cycle is ignored here
                if (psel && !penable) begin
                    cap = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_READY;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (!psel) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_READY;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_READY: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states READY is entered straight from the setup cycle,
    // before the capture registers hold the transfer, so take the live bus.
    assign xfer_wr  = cap ? pwrite    : wr_q;
    assign xfer_err = cap ? setup_err : err_q;
    assign xfer_idx = cap ? setup_idx : idx_q;
    assign rd_word  = xfer_err ? '0 : mem_q[xfer_idx];

    assign do_write = (state_q == S_READY) && psel && penable && wr_q && !err_q;

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (cap) begin
                wr_q  <= pwrite;
                err_q <= setup_err;
            end
            pready_q  <= (state_d == S_READY);
            pslverr_q <= (state_d == S_READY) ? xfer_err : 1'b0;
            if ((state_d == S_READY) && !xfer_wr) begin
                prdata_q <= rd_word;
            end
            if (do_write) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (strb_q[b]) begin
                        mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                    end
                end
            end
        end
    end

    // Datapath capture needs no reset: it is only consumed under FSM control
    always_ff @(posedge pclk) begin
        if (cap) begin
            idx_q   <= setup_idx;
            wdata_q <= pwdata;
            strb_q  <= setup_strb;
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule
